wallace_mac_accumulator: RTL and testbench
==========================================

Name: wallace_mac_accumulator

Overview:
- Sequential multiply-accumulate stage directly downstream of wallace_multiplier (8x8 unsigned, 16-bit combinational product).
- Registers operand pairs and instantiates one wallace_multiplier between pipeline registers.
- Accumulates products into groups delimited by a last flag.
- Presents each group sum on a valid/ready output port.

Parameters:
- ACC_W, 20: accumulator/result width in bits; must be >= 16.
- CNT_W, 8: width of the per-group term counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- A  input  8  multiplicand, unsigned
- B  input  8  multiplier, unsigned
- in_last  input  1  pair is the final term of the current group
- acc_valid  output  1  group result valid
- out_ready  input  1  consumer accepts result
- acc_out  output  ACC_W  group sum modulo 2^ACC_W
- acc_count  output  CNT_W  number of terms in the group, saturating
- acc_ovf  output  1  group sum exceeded 2^ACC_W-1

Behaviour:
- Reset: clk and rst are as stated in the port list; reset is synchronous and active-high (fixed).
- While rst=1 at a rising edge, all of the following are forced, regardless of other inputs:
  - in_ready=0, acc_valid=0, acc_out=0, acc_count=0, acc_ovf=0
  - S1/S2 valid flags=0, internal accumulator=0, counter=0, group-overflow flag=0
- in_ready=1 in the first cycle after rst deasserts (when not stalled).
- Pipeline:
  - S1 register holds {A, B, last, v1}.
  - The wallace_multiplier computes on the S1 operands.
  - S2 register holds {product[15:0], last, v2}.
  - A result register follows S2.
- Input transfer: in_valid && in_ready at a rising edge.
- advance = !(v2 && last2 && acc_valid && !out_ready); in_ready = advance.
- When advance=0, S1 and S2 hold their contents.
- On advance, S1 loads the input (v1 = transfer) and S2 loads S1.
- Accumulate, when v2 && advance:
  - sum = acc + zero-extended product, computed at ACC_W+1 bits.
  - The carry bit ORs into the sticky group-overflow flag.
  - The counter increments, saturating at 2^CNT_W-1.
- If last2=1:
  - The result register loads acc_out = sum[ACC_W-1:0], acc_count = counter+1 (saturated), and acc_ovf = flag | carry.
  - acc_valid is set.
  - acc, counter and flag clear to 0 in the same edge.
- If last2=0: acc <= sum[ACC_W-1:0].
- Latency: taking the accepting edge as edge 1, the result of a last-term pair is visible after edge 3, assuming no stall.
- Full throughput: one pair per cycle while out_ready=1.
- Output handshake: acc_valid && out_ready at an edge consumes the result.
  - acc_valid clears unless a new last term completes in the same edge; in that case the new result loads and acc_valid stays 1.
- acc_out, acc_count and acc_ovf are stable while acc_valid=1 and out_ready=0.
- Non-last terms continue accumulating while a result waits. Only a second completing group stalls the pipeline.
- Empty bubbles (v=0) never modify acc or the counter.
- Arithmetic: products are unsigned; acc wraps modulo 2^ACC_W; acc_ovf is sticky across the group and cleared per group.
- Reset mid-group discards any partial sum and in-flight pairs.

Test Plan:
- Single-term group, latency check: A=10, B=10, in_last=1 -> acc_valid after edge 3, acc_out=100, acc_count=1, acc_ovf=0.
- Zero operands: group {A=0,B=3}, {A=255,B=0, last} -> acc_out=0, acc_count=2, acc_ovf=0.
- Overflow boundary (ACC_W=20):
  - 16 pairs of 255*255 with last on the 16th -> acc_out=1040400, acc_ovf=0.
  - 17 pairs with last on the 17th -> acc_out=56849, acc_ovf=1, acc_count=17.
- Back-to-back groups with out_ready=1: {170*10, last}, {10*139}, {248*15, last} -> results 1700 then 5110 on consecutive valid windows, no in_ready drop.
- Backpressure: out_ready=0 with two single-term groups {58*202}, {255*255} ->
  - First result 11716 held stable.
  - in_ready drops while the second last term sits in S2.
  - Raising out_ready yields 11716 then 65025, in order, with none lost.
- Reset mid-group: pairs 10*10, 10*10 accepted, rst pulsed 1 cycle, then {3*3, last} -> acc_out=9, acc_count=1; all outputs 0 during reset.

Source files
------------

// File: rtl/wallace_mac_accumulator.sv
// Multiply-accumulate behind an 8x8 Wallace-tree multiplier. Each group sum is ready three edges after its last term is accepted.
// Only a second completing group stalls while the first result is unconsumed; the stall holds S1/S2 and drops in_ready.
module wallace_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [15:0] pp [8];
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = b[i] ? (16'(a) << i) : 16'd0;
    end
  end

  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    logic [15:0] s, c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  // Rows reduce 8 -> 6 -> 4 -> 3 -> 2 before a single carry-propagate add.
  assign {c0, s0} = csa(pp[0], pp[1], pp[2]);
  assign {c1, s1} = csa(pp[3], pp[4], pp[5]);
  assign {c2, s2} = csa(s0, c0, s1);
  assign {c3, s3} = csa(c1, pp[6], pp[7]);
  assign {c4, s4} = csa(s2, c2, s3);
  assign {c5, s5} = csa(s4, c4, c3);
  assign p = s5 + c5;
endmodule

module wallace_mac_accumulator #(
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             in_last,
  output logic             acc_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] acc_count,
  output logic             acc_ovf
);
  logic [7:0]       a1, b1;
  logic             last1, v1;
  logic [15:0]      prod, p2;
  logic             last2, v2;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             grp_ovf;
  logic [ACC_W:0]   sum;
  logic             advance, take, fire;

  wallace_multiplier u_mul (.a(a1), .b(b1), .p(prod));

  // A completed group in S2 may only retire once the result register is free or being consumed.
  assign advance  = !(v2 && last2 && acc_valid && !out_ready);
  assign in_ready = advance && !rst;
  assign take     = in_valid && in_ready;
  assign fire     = v2 && advance;
  assign sum      = {1'b0, acc} + (ACC_W+1)'(p2);
  assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      a1        <= '0;
      b1        <= '0;
      last1     <= 1'b0;
      v1        <= 1'b0;
      p2        <= '0;
      last2     <= 1'b0;
      v2        <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      grp_ovf   <= 1'b0;
      acc_valid <= 1'b0;
      acc_out   <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      if (advance) begin
        a1    <= A;
        b1    <= B;
        last1 <= in_last;
        v1    <= take;
        p2    <= prod;
        last2 <= last1;
        v2    <= v1;
      end
      if (fire) begin
        if (last2) begin
          acc_out   <= sum[ACC_W-1:0];
          acc_count <= cnt_inc;
          acc_ovf   <= grp_ovf | sum[ACC_W];
          acc       <= '0;
          cnt       <= '0;
          grp_ovf   <= 1'b0;
        end else begin
          acc     <= sum[ACC_W-1:0];
          cnt     <= cnt_inc;
          grp_ovf <= grp_ovf | sum[ACC_W];
        end
      end
      if (fire && last2) begin
        acc_valid <= 1'b1;
      end else if (acc_valid && out_ready) begin
        acc_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wallace_mac_accumulator.sv
// Scoreboarded bench: a reference sum per group is queued at each accepted last term and compared when the result appears.
module tb_wallace_mac_accumulator;
  localparam int ACC_W = 20;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       A, B;
  logic             in_last;
  logic             acc_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] acc_count;
  logic             acc_ovf;

  wallace_mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .in_last(in_last), .acc_valid(acc_valid),
    .out_ready(out_ready), .acc_out(acc_out), .acc_count(acc_count),
    .acc_ovf(acc_ovf)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          drops = 0;
  logic [31:0] exp_q[$];
  longint      ref_sum = 0;
  int          ref_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic ovf, input int cnt, input longint sum);
    logic [31:0] r;
    r = '0;
    r[ACC_W-1:0] = sum[ACC_W-1:0];
    r[ACC_W+CNT_W-1:ACC_W] = cnt[CNT_W-1:0];
    r[ACC_W+CNT_W] = ovf;
    return r;
  endfunction

  // Every visible result must match the oldest expected group; consumption pops it.
  always @(negedge clk) begin
    if (!rst && !in_ready) drops++;
    if (!rst && acc_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 32'd1, 32'd0);
      end else begin
        check("result", pack(acc_ovf, int'(acc_count), longint'(acc_out)), exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input int a, input int b, input bit last);
    bit ok;
    A = 8'(a);
    B = 8'(b);
    in_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      ref_sum += longint'(a) * longint'(b);
      if (ref_cnt < (1 << CNT_W) - 1) ref_cnt++;
      if (last) begin
        exp_q.push_back(pack(ref_sum >= (longint'(1) << ACC_W), ref_cnt, ref_sum));
        ref_sum = 0;
        ref_cnt = 0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_acc_valid", 32'(acc_valid), 32'd0);
    check("rst_outputs", pack(acc_ovf, int'(acc_count), longint'(acc_out)), 32'd0);
    exp_q.delete();
    ref_sum = 0;
    ref_cnt = 0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Single term: accepting edge is edge 1, result visible after edge 3.
    send(10, 10, 1);
    @(posedge clk);
    #1;
    check("latency_edge2", 32'(acc_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_edge3", 32'(acc_valid), 32'd1);
    check("single_sum", 32'(acc_out), 32'd100);
    drain();

    send(0, 3, 0);
    send(255, 0, 1);
    drain();

    for (int i = 1; i <= 16; i++) send(255, 255, i == 16);
    drain();
    for (int i = 1; i <= 17; i++) send(255, 255, i == 17);
    drain();

    drops = 0;
    send(170, 10, 1);
    send(10, 139, 0);
    send(248, 15, 1);
    drain();
    check("b2b_no_stall", 32'(drops), 32'd0);

    // Backpressure: the second completing group must wait in S2.
    out_ready = 1'b0;
    drops = 0;
    send(58, 202, 1);
    send(255, 255, 1);
    repeat (4) @(posedge clk);
    #1;
    check("bp_valid", 32'(acc_valid), 32'd1);
    check("bp_held_sum", 32'(acc_out), 32'd11716);
    check("bp_stall_seen", 32'(drops != 0), 32'd1);
    check("bp_both_pending", 32'(exp_q.size()), 32'd2);
    out_ready = 1'b1;
    drain();

    send(10, 10, 0);
    send(10, 10, 0);
    do_reset();
    send(3, 3, 1);
    drain();
    check("post_reset_sum", 32'(acc_out), 32'd9);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
